pu_cop0: RTL and testbench

- Commit-side consumer of the WB stage's COP control outputs: takes the per-cycle writeback record (enable, PC, COP op, exception code, branch-delay flag) and commits system-control state.
- Holds the CP0 registers Status, Cause, EPC, Count and Compare.
- Arbitrates exceptions, interrupts and ERET, then flushes the pipeline and redirects fetch.
- Kills the GPR/HI/LO write of any instruction that faults or is interrupted at WB.

---
 rtl/pu_cop0_pkg.sv | 42 ++++
 rtl/pu_cop0_timer.sv | 43 ++++
 rtl/pu_cop0.sv | 170 +++++++++++++++++
 tb/tb_pu_cop0.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pu_cop0_pkg.sv
// pu_cop0_pkg: shared definitions for the CP0 commit block.
// Holds COP op codes, CP0 register numbers, ExcCode values, the
// redirect FSM state encoding and Status/Cause bit positions.
package pu_cop0_pkg;

    // COP operation carried by the WB record
    localparam logic [2:0] COP_NOP  = 3'd0;
    localparam logic [2:0] COP_MTC0 = 3'd1;
    localparam logic [2:0] COP_ERET = 3'd2;

    // CP0 register numbers
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    // ExcCode for an external/timer interrupt
    localparam logic [4:0] EXC_INT = 5'd0;

    // Status / Cause bit positions
    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_EXC_LO = 2;

    // Redirect sequencer: event -> flush cycle -> redirect cycle -> run
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } cop0_state_e;

    // Restart word address for a trapped instruction: a delay-slot
    // instruction restarts at its branch, one word earlier.
    function automatic logic [29:0] restart_pc(input logic [29:0] pc, input logic bd);
        return bd ? (pc - 30'd1) : pc;
    endfunction

endpackage

// File: rtl/pu_cop0_timer.sv
// pu_cop0_timer: CP0 Count/Compare pair and the timer-pending flag.
// Ports: clk, rst (async active-high); count_we/compare_we with shared
// wdata (MTC0 writes); count, compare, pending outputs (all registered).
module pu_cop0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        pending
);

    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        pending_r;

    // Free-running counter, compare register and sticky match flag;
    // a Compare write clears pending even in a matching cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r   <= 32'd0;
            compare_r <= 32'd0;
            pending_r <= 1'b0;
        end else begin
            count_r <= count_we ? wdata : (count_r + 32'd1);
            if (compare_we) begin
                compare_r <= wdata;
                pending_r <= 1'b0;
            end else if (count_r == compare_r) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign pending = pending_r;

endmodule

// File: rtl/pu_cop0.sv
// pu_cop0: commit-side CP0. Consumes the WB record, holds Status, Cause,
// EPC, Count, Compare, arbitrates exception > interrupt > ERET > MTC0,
// then flushes the pipeline and redirects fetch.
// Ports: clk, rst (async active-high); wb_* writeback record; irq lines;
// cop_rd_addr/cop_rd_data MFC0 read port (combinational); wb_kill
// (combinational); flush, stall, new_pc_en, new_pc, exl.
module pu_cop0
    import pu_cop0_pkg::*;
#(
    parameter logic [29:0] EXC_VECTOR = 30'h0000_0020,
    parameter int          INT_NUM    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en,
    input  logic [29:0]        wb_pc,
    input  logic [2:0]         wb_cop_op,
    input  logic [31:0]        wb_cop_data,
    input  logic [4:0]         wb_rd_addr,
    input  logic               wb_bd,
    input  logic [3:0]         wb_exp,
    input  logic [INT_NUM-1:0] irq,
    input  logic [4:0]         cop_rd_addr,
    output logic [31:0]        cop_rd_data,
    output logic               wb_kill,
    output logic               flush,
    output logic               stall,
    output logic               new_pc_en,
    output logic [29:0]        new_pc,
    output logic               exl
);

    cop0_state_e state_r, state_nxt_s;

    logic        ie_r, exl_r, bd_r;
    logic [7:0]  im_r;
    logic [4:0]  exc_r;
    logic [29:0] epc_r;
    logic [29:0] new_pc_r;

    logic [31:0] count_s, compare_s;
    logic        timer_pend_s;
    logic [7:0]  ip_s;
    logic        take_exc_s, take_int_s, trap_s, do_eret_s, do_mtc0_s;

    // Live pending-interrupt vector: IP7 also carries the timer
    assign ip_s = {irq[5] | timer_pend_s, irq[4:0], 2'b00};

    // Event arbitration, only while running and the WB record is valid
    always_comb begin
        take_exc_s = 1'b0;
        take_int_s = 1'b0;
        do_eret_s  = 1'b0;
        do_mtc0_s  = 1'b0;
        if ((state_r == ST_RUN) && wb_en) begin
            take_exc_s = (wb_exp != 4'd0);
            take_int_s = !take_exc_s && ie_r && !exl_r && ((ip_s & im_r) != 8'd0);
            do_eret_s  = !take_exc_s && !take_int_s && (wb_cop_op == COP_ERET);
            do_mtc0_s  = !take_exc_s && !take_int_s && (wb_cop_op == COP_MTC0);
        end else begin
            take_exc_s = 1'b0;
        end
    end

    assign trap_s  = take_exc_s | take_int_s;
    assign wb_kill = trap_s;

    // Redirect sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: any accepted trap or ERET starts a two-cycle redirect
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN:   state_nxt_s = (trap_s || do_eret_s) ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_nxt_s = ST_REDIR;
            ST_REDIR: state_nxt_s = ST_RUN;
            default:  state_nxt_s = ST_RUN;
        endcase
    end

    // Sequencer outputs decoded from the state register
    always_comb begin
        flush     = 1'b0;
        stall     = 1'b0;
        new_pc_en = 1'b0;
        case (state_r)
            ST_FLUSH: begin
                flush = 1'b1;
                stall = 1'b1;
            end
            ST_REDIR: begin
                stall     = 1'b1;
                new_pc_en = 1'b1;
            end
            default: begin
                flush = 1'b0;
            end
        endcase
    end

    // Status/Cause/EPC and redirect target update; a trap while EXL is
    // already set keeps the original EPC/BD so the outer return survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_r     <= 1'b0;
            exl_r    <= 1'b0;
            im_r     <= 8'd0;
            bd_r     <= 1'b0;
            exc_r    <= 5'd0;
            epc_r    <= 30'd0;
            new_pc_r <= 30'd0;
        end else if (trap_s) begin
            if (!exl_r) begin
                epc_r <= restart_pc(wb_pc, wb_bd);
                bd_r  <= wb_bd;
            end
            exc_r    <= take_exc_s ? {1'b0, wb_exp} : EXC_INT;
            exl_r    <= 1'b1;
            new_pc_r <= EXC_VECTOR;
        end else if (do_eret_s) begin
            exl_r    <= 1'b0;
            new_pc_r <= epc_r;
        end else if (do_mtc0_s) begin
            case (wb_rd_addr)
                CP0_STATUS: begin
                    ie_r  <= wb_cop_data[STATUS_IE];
                    exl_r <= wb_cop_data[STATUS_EXL];
                    im_r  <= wb_cop_data[STATUS_IM_LO +: 8];
                end
                CP0_EPC: epc_r <= wb_cop_data[31:2];
                default: epc_r <= epc_r;
            endcase
        end
    end

    pu_cop0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (do_mtc0_s && (wb_rd_addr == CP0_COUNT)),
        .compare_we (do_mtc0_s && (wb_rd_addr == CP0_COMPARE)),
        .wdata      (wb_cop_data),
        .count      (count_s),
        .compare    (compare_s),
        .pending    (timer_pend_s)
    );

    // MFC0 read mux; unmapped registers read zero
    always_comb begin
        cop_rd_data = 32'd0;
        case (cop_rd_addr)
            CP0_COUNT:   cop_rd_data = count_s;
            CP0_COMPARE: cop_rd_data = compare_s;
            CP0_STATUS:  cop_rd_data = {16'd0, im_r, 6'd0, exl_r, ie_r};
            CP0_CAUSE:   cop_rd_data = {bd_r, 15'd0, ip_s, 1'b0, exc_r, 2'b00};
            CP0_EPC:     cop_rd_data = {epc_r, 2'b00};
            default:     cop_rd_data = 32'd0;
        endcase
    end

    assign new_pc = new_pc_r;
    assign exl    = exl_r;

endmodule

// File: tb/tb_pu_cop0.sv
// tb_pu_cop0: directed plus randomized bench for pu_cop0 with a
// behavioural CP0 model tracked cycle by cycle.
module tb_pu_cop0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en = 1'b0;
    logic [29:0] wb_pc = 30'd0;
    logic [2:0]  wb_cop_op = 3'd0;
    logic [31:0] wb_cop_data = 32'd0;
    logic [4:0]  wb_rd_addr = 5'd0;
    logic        wb_bd = 1'b0;
    logic [3:0]  wb_exp = 4'd0;
    logic [5:0]  irq = 6'd0;
    logic [4:0]  cop_rd_addr = 5'd0;
    logic [31:0] cop_rd_data;
    logic        wb_kill, flush, stall, new_pc_en, exl;
    logic [29:0] new_pc;

    int checks = 0;
    int failures = 0;

    // model state
    logic        m_ie, m_exl, m_bd, m_pend;
    logic [7:0]  m_im;
    logic [4:0]  m_exc;
    logic [29:0] m_epc, m_npc;
    logic [31:0] m_count, m_compare;
    int          m_busy;   // cycles of redirect still to run: 2 flush, 1 redirect

    pu_cop0 dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_pc(wb_pc), .wb_cop_op(wb_cop_op),
        .wb_cop_data(wb_cop_data), .wb_rd_addr(wb_rd_addr), .wb_bd(wb_bd),
        .wb_exp(wb_exp), .irq(irq), .cop_rd_addr(cop_rd_addr),
        .cop_rd_data(cop_rd_data), .wb_kill(wb_kill), .flush(flush),
        .stall(stall), .new_pc_en(new_pc_en), .new_pc(new_pc), .exl(exl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_ie = 1'b0; m_exl = 1'b0; m_bd = 1'b0; m_pend = 1'b0;
        m_im = 8'd0; m_exc = 5'd0; m_epc = 30'd0; m_npc = 30'd0;
        m_count = 32'd0; m_compare = 32'd0; m_busy = 0;
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a, input logic [7:0] ip);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return {16'd0, m_im, 6'd0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'd0, ip, 1'b0, m_exc, 2'b00};
            5'd14:   return {m_epc, 2'b00};
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive, check before the edge, advance the model at the edge
    task automatic cyc(input logic en, input logic [29:0] pc, input logic [2:0] op,
                       input logic [31:0] data, input logic [4:0] rd, input logic bd,
                       input logic [3:0] ex, input logic [5:0] iv, input logic [4:0] ra);
        logic [7:0] ip;
        logic trap, hit;
        wb_en = en; wb_pc = pc; wb_cop_op = op; wb_cop_data = data;
        wb_rd_addr = rd; wb_bd = bd; wb_exp = ex; irq = iv; cop_rd_addr = ra;
        #1;
        ip   = {iv[5] | m_pend, iv[4:0], 2'b00};
        trap = (m_busy == 0) && en &&
               ((ex != 4'd0) || (m_ie && !m_exl && ((ip & m_im) != 8'd0)));
        chk("wb_kill", {31'd0, wb_kill}, {31'd0, trap});
        chk("rd_data", cop_rd_data, mread(ra, ip));
        chk("flush", {31'd0, flush}, {31'd0, m_busy == 2});
        chk("stall", {31'd0, stall}, {31'd0, m_busy != 0});
        chk("new_pc_en", {31'd0, new_pc_en}, {31'd0, m_busy == 1});
        chk("new_pc", {2'd0, new_pc}, {2'd0, m_npc});
        chk("exl", {31'd0, exl}, {31'd0, m_exl});
        @(posedge clk);
        hit = (m_count == m_compare);
        m_count = m_count + 32'd1;
        if (hit) m_pend = 1'b1;
        if (m_busy != 0) begin
            m_busy = m_busy - 1;
        end else if (en) begin
            if (trap) begin
                if (!m_exl) begin
                    m_epc = bd ? pc - 30'd1 : pc;
                    m_bd  = bd;
                end
                m_exc = {1'b0, ex};
                m_exl = 1'b1; m_npc = 30'h20; m_busy = 2;
            end else if (op == 3'd2) begin
                m_exl = 1'b0; m_npc = m_epc; m_busy = 2;
            end else if (op == 3'd1) begin
                case (rd)
                    5'd9:  m_count = data;
                    5'd11: begin m_compare = data; m_pend = 1'b0; end
                    5'd12: begin m_ie = data[0]; m_exl = data[1]; m_im = data[15:8]; end
                    5'd14: m_epc = data[31:2];
                    default: ;
                endcase
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 30'd0, 3'd0, 32'd0, 5'd0, 1'b0, 4'd0, 6'd0, 5'd9);
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] expv);
        cop_rd_addr = a;
        #1;
        chk(tag, cop_rd_data, expv);
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_new_pc_en", {31'd0, new_pc_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // idle after reset
        idle(5);
        peek("count5", 5'd9, 32'd5);
        peek("status0", 5'd12, 32'd0);

        // plain exception, not in a delay slot
        cyc(1'b1, 30'h100, 3'd0, 32'd0, 5'd0, 1'b0, 4'h8, 6'd0, 5'd13);
        idle(2);
        peek("epc_exc", 5'd14, 32'h0000_0400);
        peek("cause_exc", 5'd13, 32'h0000_8020);

        // return, then exception in a delay slot
        cyc(1'b1, 30'h0, 3'd2, 32'd0, 5'd0, 1'b0, 4'd0, 6'd0, 5'd14);
        idle(2);
        cyc(1'b1, 30'h101, 3'd0, 32'd0, 5'd0, 1'b1, 4'h8, 6'd0, 5'd13);
        idle(2);
        peek("epc_bd", 5'd14, 32'h0000_0400);
        peek("cause_bd", 5'd13, 32'h8000_8020);

        // enable IM2, then irq[0] interrupts
        cyc(1'b1, 30'h0, 3'd2, 32'd0, 5'd0, 1'b0, 4'd0, 6'd0, 5'd12);
        idle(2);
        cyc(1'b1, 30'h1ff, 3'd1, 32'h0000_0401, 5'd12, 1'b0, 4'd0, 6'd0, 5'd12);
        cyc(1'b1, 30'h200, 3'd0, 32'd0, 5'd0, 1'b0, 4'd0, 6'd1, 5'd13);
        peek("epc_int", 5'd14, 32'h0000_0800);
        peek("cause_int", 5'd13, 32'h0000_8400);
        idle(2);

        // ERET back to 0x200, then exception + interrupt together
        cyc(1'b1, 30'h0, 3'd2, 32'd0, 5'd0, 1'b0, 4'd0, 6'd0, 5'd12);
        idle(2);
        cyc(1'b1, 30'h200, 3'd0, 32'd0, 5'd0, 1'b0, 4'h5, 6'd1, 5'd13);
        peek("cause_exc_int", 5'd13, 32'h0000_8414);
        idle(2);

        // ERET; WB records during FLUSH/REDIR are ignored
        cyc(1'b1, 30'h0, 3'd2, 32'd0, 5'd0, 1'b0, 4'd0, 6'd0, 5'd14);
        cyc(1'b1, 30'h300, 3'd0, 32'd0, 5'd0, 1'b0, 4'h3, 6'd0, 5'd12);
        cyc(1'b1, 30'h301, 3'd1, 32'd0, 5'd12, 1'b0, 4'd0, 6'd0, 5'd12);
        chk("eret_new_pc", {2'd0, new_pc}, 32'h0000_0200);
        peek("status_kept", 5'd12, 32'h0000_0401);

        // timer: Count=10, Compare=20, pending after the match
        cyc(1'b1, 30'h400, 3'd1, 32'd10, 5'd9, 1'b0, 4'd0, 6'd0, 5'd9);
        cyc(1'b1, 30'h401, 3'd1, 32'd20, 5'd11, 1'b0, 4'd0, 6'd0, 5'd9);
        peek("cause_nopend", 5'd13, 32'h0000_0014);
        idle(10);
        peek("count21", 5'd9, 32'd21);
        peek("cause_pend", 5'd13, 32'h0000_8014);
        cyc(1'b1, 30'h402, 3'd1, 32'd0, 5'd11, 1'b0, 4'd0, 6'd0, 5'd13);
        peek("cause_clr", 5'd13, 32'h0000_0014);

        // reset in the middle of a FLUSH
        cyc(1'b1, 30'h500, 3'd0, 32'd0, 5'd0, 1'b0, 4'h2, 6'd0, 5'd13);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_mid_flush", {31'd0, flush}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_new_pc", {2'd0, new_pc}, 32'd0);
        chk("rst_mid_exl", {31'd0, exl}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [4:0]  rd, ra;
            logic [31:0] d;
            logic [4:0]  pick [6];
            pick[0] = 5'd9; pick[1] = 5'd11; pick[2] = 5'd12;
            pick[3] = 5'd13; pick[4] = 5'd14; pick[5] = 5'($urandom_range(0, 31));
            rd = pick[$urandom_range(0, 5)];
            ra = pick[$urandom_range(0, 5)];
            d  = $urandom;
            if (rd == 5'd11 && $urandom_range(0, 1) == 0)
                d = m_count + 32'($urandom_range(0, 6));
            if (rd == 5'd12 && $urandom_range(0, 2) != 0)
                d = d & 32'h0000_FF01;
            cyc($urandom_range(0, 9) < 7, 30'($urandom), 3'($urandom_range(0, 3)), d, rd,
                1'($urandom), ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0, ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
